// File: rtl/vga_quadrant_ctrl.sv
// 640x480@60 raster timing generator that also drives the mux4 quadrant select.
// An optional per-frame rotation cycles which colour source paints which quadrant.
module vga_quadrant_ctrl #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       rot_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [1:0] sel,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SW);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SW);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] H_HALF   = 10'(H_VIS / 2);
  localparam logic [9:0] V_HALF   = 10'(V_VIS / 2);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [1:0] rot_q, rot_d;
  logic       frame_start_q, frame_start_d;

  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;
  logic [1:0] quad;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    rot_d         = rot_q;
    h_wrap        = (h_cnt_q == H_LAST);
    v_wrap        = (v_cnt_q == V_LAST);
    frame_wrap    = pix_en && h_wrap && v_wrap;
    frame_start_d = frame_wrap;

    if (pix_en) begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
      end
    end

    // Rotation only ever moves on the wrap edge, so a frame never changes mapping midway.
    if (frame_wrap && rot_en) begin
      rot_d = rot_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      rot_q         <= 2'd0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rot_q         <= rot_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Every output is a pure decode of the registers, so all of them share one pixel position.
  always_comb begin
    hsync       = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vsync       = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    video_on    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    x           = h_cnt_q;
    y           = v_cnt_q;
    quad        = {v_cnt_q >= V_HALF, h_cnt_q >= H_HALF};
    sel         = video_on ? (quad + rot_q) : 2'b00;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_vga_quadrant_ctrl.sv
// Directed bench: a full-size instance checks reset and line timing, a shrunken
// instance checks whole frames, rotation and asynchronous reset within a short run.
module tb_vga_quadrant_ctrl;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // Shrunken raster geometry for the frame-level instance.
  localparam int BH_VIS = 64;
  localparam int BH_FP  = 4;
  localparam int BH_SW  = 8;
  localparam int BH_BP  = 4;
  localparam int BV_VIS = 48;
  localparam int BV_FP  = 2;
  localparam int BV_SW  = 2;
  localparam int BV_BP  = 3;
  localparam int BH_TOT = BH_VIS + BH_FP + BH_SW + BH_BP;
  localparam int BV_TOT = BV_VIS + BV_FP + BV_SW + BV_BP;
  localparam int B_FRAME = BH_TOT * BV_TOT;

  logic       rst_n_a = 1'b0, pix_en_a = 1'b0, rot_en_a = 1'b0;
  logic       hsync_a, vsync_a, video_on_a, frame_start_a;
  logic [9:0] x_a, y_a;
  logic [1:0] sel_a;

  logic       rst_n_b = 1'b0, pix_en_b = 1'b0, rot_en_b = 1'b0;
  logic       hsync_b, vsync_b, video_on_b, frame_start_b;
  logic [9:0] x_b, y_b;
  logic [1:0] sel_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference raster for instance B.
  int         mx = 0, my = 0;
  logic [1:0] mrot = 2'd0;
  logic       mfs = 1'b0;
  int         b_errs = 0, vs_low = 0, fs_cnt = 0;
  logic [25:0] first_act, first_exp;

  vga_quadrant_ctrl dut_a (
    .clk(clk), .rst_n(rst_n_a), .pix_en(pix_en_a), .rot_en(rot_en_a),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
    .x(x_a), .y(y_a), .sel(sel_a), .frame_start(frame_start_a)
  );

  vga_quadrant_ctrl #(
    .H_VIS(BH_VIS), .H_FP(BH_FP), .H_SW(BH_SW), .H_BP(BH_BP),
    .V_VIS(BV_VIS), .V_FP(BV_FP), .V_SW(BV_SW), .V_BP(BV_BP)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .pix_en(pix_en_b), .rot_en(rot_en_b),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .x(x_b), .y(y_b), .sel(sel_b), .frame_start(frame_start_b)
  );

  wire [25:0] obs_a = {hsync_a, vsync_a, video_on_a, sel_a, frame_start_a, x_a, y_a};
  wire [25:0] obs_b = {hsync_b, vsync_b, video_on_b, sel_b, frame_start_b, x_b, y_b};

  function automatic logic [25:0] model_vec(int hx, int vy, logic [1:0] r, logic fs);
    logic hs, vs, vo;
    logic [1:0] q, s;
    hs   = !((hx >= BH_VIS + BH_FP) && (hx < BH_VIS + BH_FP + BH_SW));
    vs   = !((vy >= BV_VIS + BV_FP) && (vy < BV_VIS + BV_FP + BV_SW));
    vo   = (hx < BH_VIS) && (vy < BV_VIS);
    q[1] = (vy >= BV_VIS / 2);
    q[0] = (hx >= BH_VIS / 2);
    s    = vo ? q + r : 2'b00;
    return {hs, vs, vo, s, fs, 10'(hx), 10'(vy)};
  endfunction

  task automatic tick_a(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_a();
    rst_n_a  = 1'b0;
    pix_en_a = 1'b0;
    #2;
    rst_n_a  = 1'b1;
  endtask

  task automatic reset_b();
    rst_n_b  = 1'b0;
    pix_en_b = 1'b0;
    mx = 0; my = 0; mrot = 2'd0; mfs = 1'b0;
    #2;
    rst_n_b  = 1'b1;
  endtask

  // Advance instance B by n clocks alongside the reference raster, tallying disagreements.
  task automatic step_b(input int n);
    logic fs_n;
    logic [25:0] exp_v;
    for (int i = 0; i < n; i++) begin
      fs_n = pix_en_b && (mx == BH_TOT - 1) && (my == BV_TOT - 1);
      if (pix_en_b) begin
        if (mx == BH_TOT - 1) begin
          mx = 0;
          my = (my == BV_TOT - 1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      if (fs_n && rot_en_b) mrot = mrot + 2'd1;
      mfs = fs_n;
      @(posedge clk);
      #1;
      exp_v = model_vec(mx, my, mrot, mfs);
      if (obs_b !== exp_v) begin
        if (b_errs == 0) begin
          first_act = obs_b;
          first_exp = exp_v;
        end
        b_errs++;
      end
      if (vsync_b === 1'b0) vs_low++;
      if (frame_start_b === 1'b1) fs_cnt++;
    end
  endtask

  task automatic test_reset();
    logic [25:0] idle;
    idle = {1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 10'd0, 10'd0};
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    pix_en_a = 1'b0; pix_en_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (obs_a !== idle) begin
        n_fail++;
        $display("FAIL reset_idle_a cycle %0d: got %h want %h", i, obs_a, idle);
      end
      n_checks++;
      if (obs_b !== idle) begin
        n_fail++;
        $display("FAIL reset_idle_b cycle %0d: got %h want %h", i, obs_b, idle);
      end
    end
  endtask

  task automatic test_quadrants_a();
    int          steps[4];
    logic [22:0] want[4];
    steps[0] = 319; want[0] = {1'b1, 2'b00, 10'd319, 10'd0};
    steps[1] = 1;   want[1] = {1'b1, 2'b01, 10'd320, 10'd0};
    steps[2] = 319; want[2] = {1'b1, 2'b01, 10'd639, 10'd0};
    steps[3] = 1;   want[3] = {1'b0, 2'b00, 10'd640, 10'd0};
    reset_a();
    pix_en_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick_a(steps[k]);
      n_checks++;
      if ({video_on_a, sel_a, x_a, y_a} !== want[k]) begin
        n_fail++;
        $display("FAIL quad_a_%0d: got vo/sel/x/y %h want %h", k,
                 {video_on_a, sel_a, x_a, y_a}, want[k]);
      end
    end
    pix_en_a = 1'b0;
  endtask

  task automatic test_hsync_line();
    int errs, low;
    logic exp_hs;
    reset_a();
    pix_en_a = 1'b1;
    errs = 0;
    low  = 0;
    for (int i = 0; i < 800; i++) begin
      exp_hs = !((i >= 656) && (i < 752));
      if ((hsync_a !== exp_hs) || (x_a !== 10'(i)) || (y_a !== 10'd0)) errs++;
      if (hsync_a === 1'b0) low++;
      tick_a(1);
    end
    pix_en_a = 1'b0;
    n_checks++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL hsync_window: %0d positions wrong, want 0", errs);
    end
    n_checks++;
    if (low !== 96) begin
      n_fail++;
      $display("FAIL hsync_low_ticks: got %0d want 96", low);
    end
    n_checks++;
    if ({x_a, y_a} !== {10'd0, 10'd1}) begin
      n_fail++;
      $display("FAIL line_wrap: got x=%0d y=%0d want x=0 y=1", x_a, y_a);
    end
  endtask

  task automatic test_quadrants_b();
    int          steps[3];
    logic [21:0] want[3];
    steps[0] = BH_VIS / 2;
    want[0]  = {2'b01, 10'(BH_VIS / 2), 10'd0};
    steps[1] = (BV_VIS / 2) * BH_TOT - BH_VIS / 2;
    want[1]  = {2'b10, 10'd0, 10'(BV_VIS / 2)};
    steps[2] = (BV_VIS / 2 - 1) * BH_TOT + BH_VIS - 1;
    want[2]  = {2'b11, 10'(BH_VIS - 1), 10'(BV_VIS - 1)};
    reset_b();
    pix_en_b = 1'b1;
    rot_en_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_b(steps[k]);
      n_checks++;
      if ({sel_b, x_b, y_b} !== want[k]) begin
        n_fail++;
        $display("FAIL quad_b_%0d: got sel/x/y %h want %h", k, {sel_b, x_b, y_b}, want[k]);
      end
    end
  endtask

  task automatic test_frame();
    reset_b();
    pix_en_b = 1'b1;
    rot_en_b = 1'b0;
    vs_low = 0;
    fs_cnt = 0;
    step_b(B_FRAME);
    n_checks++;
    if (vs_low !== BV_SW * BH_TOT) begin
      n_fail++;
      $display("FAIL vsync_low_ticks: got %0d want %0d", vs_low, BV_SW * BH_TOT);
    end
    n_checks++;
    if (fs_cnt !== 1) begin
      n_fail++;
      $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
    end
    n_checks++;
    if ({frame_start_b, sel_b, x_b, y_b} !== {1'b1, 2'b00, 10'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL frame_wrap_norot: got fs=%b sel=%b x=%0d y=%0d want fs=1 sel=00 (0,0)",
               frame_start_b, sel_b, x_b, y_b);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] want[5];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b11; want[3] = 2'b00; want[4] = 2'b00;
    reset_b();
    pix_en_b = 1'b1;
    rot_en_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) rot_en_b = 1'b0;
      step_b(B_FRAME);
      n_checks++;
      if ({frame_start_b, sel_b, x_b, y_b} !== {1'b1, want[k], 10'd0, 10'd0}) begin
        n_fail++;
        $display("FAIL rot_wrap_%0d: got fs=%b sel=%b x=%0d y=%0d want fs=1 sel=%b (0,0)",
                 k, frame_start_b, sel_b, x_b, y_b, want[k]);
      end
      if (k == 0) begin
        // A stalled pixel clock must still drop frame_start after one clk.
        pix_en_b = 1'b0;
        step_b(1);
        n_checks++;
        if ({frame_start_b, sel_b, x_b, y_b} !== {1'b0, 2'b01, 10'd0, 10'd0}) begin
          n_fail++;
          $display("FAIL fs_clear_hold: got fs=%b sel=%b x=%0d y=%0d want fs=0 sel=01 (0,0)",
                   frame_start_b, sel_b, x_b, y_b);
        end
        pix_en_b = 1'b1;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [25:0] idle;
    idle = {1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 10'd0, 10'd0};
    reset_b();
    pix_en_b = 1'b1;
    rot_en_b = 1'b1;
    step_b(2 * B_FRAME);
    rot_en_b = 1'b0;
    step_b(30 * BH_TOT + 40);
    n_checks++;
    if ({sel_b, x_b, y_b} !== {2'b01, 10'd40, 10'd30}) begin
      n_fail++;
      $display("FAIL pre_reset_pos: got sel=%b x=%0d y=%0d want sel=01 (40,30)", sel_b, x_b, y_b);
    end
    rst_n_b = 1'b0;
    #2;
    n_checks++;
    if (obs_b !== idle) begin
      n_fail++;
      $display("FAIL async_reset_b: got %h want %h", obs_b, idle);
    end
    mx = 0; my = 0; mrot = 2'd0; mfs = 1'b0;
    #3;
    rst_n_b = 1'b1;
    step_b(1);
    n_checks++;
    if ({x_b, y_b} !== {10'd1, 10'd0}) begin
      n_fail++;
      $display("FAIL post_reset_step: got x=%0d y=%0d want x=1 y=0", x_b, y_b);
    end
    step_b(BH_VIS / 2 - 1);
    n_checks++;
    if ({sel_b, x_b} !== {2'b01, 10'(BH_VIS / 2)}) begin
      n_fail++;
      $display("FAIL post_reset_rot: got sel=%b x=%0d want sel=01 x=%0d", sel_b, x_b, BH_VIS / 2);
    end
    pix_en_b = 1'b0;
  endtask

  task automatic test_model_agreement();
    n_checks++;
    if (b_errs !== 0) begin
      n_fail++;
      $display("FAIL raster_model: %0d cycles disagree, first got %h want %h",
               b_errs, first_act, first_exp);
    end
  endtask

  initial begin
    test_reset();
    test_quadrants_a();
    test_hsync_line();
    test_quadrants_b();
    test_frame();
    test_rotation();
    test_async_reset();
    test_model_agreement();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
